// File: rtl/peripheral_scan7seg.sv
// peripheral_scan7seg: time-multiplexed driver for NDIG common-anode 7-segment digits that
// share one external decoder. Each digit slot is BLANK_CYC all-off cycles followed by SCAN_DIV
// cycles with its anode driven. Digit codes are written into shadow registers and copied to
// the active set by a commit, so the display never shows a half-updated value.
//
// Ports:
//   clk, rst_n      - clock (rising edge) and asynchronous active-low reset
//   enable          - scanning runs while high
//   wr_en/addr/data - shadow digit write; data[4] = extended-set flag, data[3:0] = code
//   commit          - request a shadow-to-active copy at the next frame boundary (or in OFF)
//   blink_mask      - digits that blank their ON slot while the blink phase is set
//   an_n            - active-low anode selects
//   dig_code/ext    - shared decoder D and EXTENDED inputs
//   commit_pending  - a commit is waiting to be applied
//   frame_done      - one-cycle pulse at each frame boundary
module peripheral_scan7seg #(
    parameter int unsigned NDIG         = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYC    = 500,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    wr_en,
    input  logic [$clog2(NDIG)-1:0] wr_addr,
    input  logic [4:0]              wr_data,
    input  logic                    commit,
    input  logic [NDIG-1:0]         blink_mask,
    output logic [NDIG-1:0]         an_n,
    output logic [3:0]              dig_code,
    output logic                    dig_ext,
    output logic                    commit_pending,
    output logic                    frame_done
);

    localparam int unsigned IdxW   = $clog2(NDIG);
    localparam int unsigned CntMax = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam int unsigned BlkW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [4:0]  BlankCode = 5'b10000;

    typedef enum logic [1:0] {StOff, StBlank, StOn} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [BlkW-1:0] blk_cnt_q, blk_cnt_d;
    logic            phase_q, phase_d;
    logic [4:0]      shadow_q [NDIG];
    logic [4:0]      shadow_d [NDIG];
    logic [4:0]      active_q [NDIG];
    logic [4:0]      active_d [NDIG];
    logic            commit_pending_q, commit_pending_d;
    logic [NDIG-1:0] an_n_q, an_n_d;
    logic [3:0]      dig_code_q, dig_code_d;
    logic            dig_ext_q, dig_ext_d;
    logic            frame_done_q, frame_done_d;
    logic            boundary;
    logic            do_copy;
    logic            addr_ok;

    // Out-of-range write addresses only exist when NDIG is not a power of two.
    if (NDIG == (1 << IdxW)) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_part
        assign addr_ok = (wr_addr < IdxW'(NDIG));
    end

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        cnt_d            = cnt_q;
        blk_cnt_d        = blk_cnt_q;
        phase_d          = phase_q;
        shadow_d         = shadow_q;
        active_d         = active_q;
        commit_pending_d = commit_pending_q;
        boundary         = 1'b0;

        unique case (state_q)
            StOff: begin
                idx_d = '0;
                cnt_d = '0;
                if (enable) state_d = StBlank;
            end
            StBlank: begin
                if (cnt_q == CntW'(BLANK_CYC - 1)) begin
                    state_d = StOn;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StOn: begin
                if (cnt_q == CntW'(SCAN_DIV - 1)) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    if (idx_q == IdxW'(NDIG - 1)) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StOff;
        endcase

        // Dropping enable wins over any slot transition, including a frame boundary.
        if (!enable) begin
            state_d  = StOff;
            idx_d    = '0;
            cnt_d    = '0;
            boundary = 1'b0;
        end

        if (state_d == StOff) begin
            phase_d   = 1'b0;
            blk_cnt_d = '0;
        end else if (boundary) begin
            if (blk_cnt_q == BlkW'(BLINK_FRAMES - 1)) begin
                blk_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end

        // Copy takes the registered shadow, so a same-cycle write lands only in shadow.
        do_copy = commit_pending_q && (boundary || state_q == StOff);
        if (do_copy) active_d = shadow_q;
        if (wr_en && addr_ok) shadow_d[wr_addr] = wr_data;

        if (commit) begin
            commit_pending_d = 1'b1;
        end else if (do_copy) begin
            commit_pending_d = 1'b0;
        end

        // Outputs are derived from next state so the registered copies line up with the FSM.
        an_n_d = '1;
        if (state_d == StOn && !(phase_d && blink_mask[idx_d])) an_n_d[idx_d] = 1'b0;
        {dig_ext_d, dig_code_d} = active_d[idx_d];
        frame_done_d = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StOff;
            idx_q            <= '0;
            cnt_q            <= '0;
            blk_cnt_q        <= '0;
            phase_q          <= 1'b0;
            shadow_q         <= '{default: BlankCode};
            active_q         <= '{default: BlankCode};
            commit_pending_q <= 1'b0;
            an_n_q           <= '1;
            dig_code_q       <= 4'b0000;
            dig_ext_q        <= 1'b1;
            frame_done_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            cnt_q            <= cnt_d;
            blk_cnt_q        <= blk_cnt_d;
            phase_q          <= phase_d;
            shadow_q         <= shadow_d;
            active_q         <= active_d;
            commit_pending_q <= commit_pending_d;
            an_n_q           <= an_n_d;
            dig_code_q       <= dig_code_d;
            dig_ext_q        <= dig_ext_d;
            frame_done_q     <= frame_done_d;
        end
    end

    assign an_n           = an_n_q;
    assign dig_code       = dig_code_q;
    assign dig_ext        = dig_ext_q;
    assign commit_pending = commit_pending_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_peripheral_scan7seg.sv
// Directed bench for peripheral_scan7seg: a 4-digit instance for scanning, commit, blink,
// enable and reset behaviour, and a 5-digit instance for out-of-range writes.
module tb_peripheral_scan7seg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       enable, wr_en, commit;
    logic [1:0] wr_addr;
    logic [4:0] wr_data;
    logic [3:0] blink_mask;
    logic [3:0] an_n, dig_code;
    logic       dig_ext, commit_pending, frame_done;

    logic       b_enable, b_wr_en, b_commit;
    logic [2:0] b_wr_addr;
    logic [4:0] b_wr_data;
    logic [4:0] b_blink_mask;
    logic [4:0] b_an_n;
    logic [3:0] b_dig_code;
    logic       b_dig_ext, b_commit_pending, b_frame_done;

    int n_checks = 0;
    int n_errors = 0;

    peripheral_scan7seg #(
        .NDIG(4), .SCAN_DIV(4), .BLANK_CYC(2), .BLINK_FRAMES(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .blink_mask(blink_mask), .an_n(an_n),
        .dig_code(dig_code), .dig_ext(dig_ext), .commit_pending(commit_pending),
        .frame_done(frame_done)
    );

    peripheral_scan7seg #(
        .NDIG(5), .SCAN_DIV(4), .BLANK_CYC(2), .BLINK_FRAMES(2)
    ) u_dut5 (
        .clk(clk), .rst_n(rst_n), .enable(b_enable), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .commit(b_commit), .blink_mask(b_blink_mask), .an_n(b_an_n),
        .dig_code(b_dig_code), .dig_ext(b_dig_ext), .commit_pending(b_commit_pending),
        .frame_done(b_frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         slot, pos, f;
        logic       phase;
        logic [3:0] an_exp, code_exp;
        logic [4:0] b_an_exp;

        rst_n = 1'b0;
        enable = 0; wr_en = 0; commit = 0; wr_addr = '0; wr_data = '0; blink_mask = '0;
        b_enable = 0; b_wr_en = 0; b_commit = 0; b_wr_addr = '0; b_wr_data = '0;
        b_blink_mask = '0;
        step();
        step();
        check("rst_an", an_n, 4'hF);
        check("rst_code", dig_code, 4'h0);
        check("rst_ext", dig_ext, 1'b1);
        check("rst_pend", commit_pending, 1'b0);
        check("rst_fd", frame_done, 1'b0);
        check("rst5_an", b_an_n, 5'h1F);
        check("rst5_code", b_dig_code, 4'h0);
        check("rst5_ext", b_dig_ext, 1'b1);

        #2 rst_n = 1'b1;
        step();

        // Load digits 1..4 and commit while OFF.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = 5'(i + 1);
            step();
        end
        wr_en = 1'b0; commit = 1'b1;
        step();
        check("commit_set", commit_pending, 1'b1);
        commit = 1'b0;
        step();
        check("off_copy_pend", commit_pending, 1'b0);
        check("off_copy_code", dig_code, 4'h1);
        check("off_copy_ext", dig_ext, 1'b0);
        check("off_an", an_n, 4'hF);

        // Six frames of 24 cycles; k counts cycles from the edge that leaves OFF.
        blink_mask = 4'b0100;
        enable = 1'b1;
        step();
        for (int k = 0; k < 144; k++) begin
            slot  = (k / 6) % 4;
            pos   = k % 6;
            f     = k / 24;
            phase = ((f / 2) % 2) == 1;
            an_exp = 4'hF;
            if (pos >= 2 && !(phase && slot == 2)) an_exp[slot] = 1'b0;
            case (slot)
                0:       code_exp = (f >= 4) ? 4'hA : 4'h1;
                1:       code_exp = 4'h2;
                2:       code_exp = (f >= 2) ? 4'hF : 4'h3;
                default: code_exp = 4'h4;
            endcase
            check("scan_an", an_n, an_exp);
            check("scan_code", dig_code, code_exp);
            check("scan_ext", dig_ext, (slot == 0 && f >= 4));
            check("scan_fd", frame_done, (k > 0 && k % 24 == 0));
            check("scan_pend", commit_pending, ((k >= 35 && k < 48) || (k >= 72 && k < 96)));

            wr_en = 1'b0; commit = 1'b0;
            if (k == 34) begin
                // Write and commit together mid-frame.
                wr_en = 1'b1; wr_addr = 2'd2; wr_data = 5'h0F; commit = 1'b1;
            end else if (k == 71) begin
                // Commit sampled on the boundary edge itself: waits a whole frame.
                wr_en = 1'b1; wr_addr = 2'd0; wr_data = 5'h1A; commit = 1'b1;
            end
            step();
        end
        wr_en = 1'b0; commit = 1'b0;
        check("wrap_fd", frame_done, 1'b1);
        step();
        step();
        check("pre_drop_an", an_n, 4'b1110);

        // Drop enable mid-ON.
        enable = 1'b0;
        step();
        check("drop_an", an_n, 4'hF);
        check("drop_fd", frame_done, 1'b0);
        step();
        check("off_code", dig_code, 4'hA);
        check("off_ext", dig_ext, 1'b1);

        // Restart goes through BLANK at index 0; blink phase was cleared in OFF.
        enable = 1'b1; b_enable = 1'b1;
        for (int j = 0; j < 15; j++) begin
            step();
            if (j == 0) check("restart_blank", an_n, 4'hF);
            if (j == 0) check("restart_code", dig_code, 4'hA);
            if (j == 2) check("restart_on0", an_n, 4'b1110);
            if (j == 14) check("restart_on2", an_n, 4'b1011);
        end
        check("pre_rst5_an", b_an_n, 5'b11011);

        // Asynchronous reset mid-slot.
        #3 rst_n = 1'b0;
        #1;
        check("arst_an", an_n, 4'hF);
        check("arst_code", dig_code, 4'h0);
        check("arst_ext", dig_ext, 1'b1);
        check("arst_pend", commit_pending, 1'b0);
        check("arst_fd", frame_done, 1'b0);
        check("arst5_an", b_an_n, 5'h1F);
        enable = 1'b0; b_enable = 1'b0;
        #3 rst_n = 1'b1;
        step();
        check("post_rst_code", dig_code, 4'h0);
        check("post_rst_ext", dig_ext, 1'b1);

        // Out-of-range writes on the 5-digit instance must not reach any digit.
        b_wr_en = 1'b1; b_wr_data = 5'h03;
        for (int a = 5; a < 8; a++) begin
            b_wr_addr = 3'(a);
            step();
        end
        b_wr_en = 1'b0; b_commit = 1'b1;
        step();
        b_commit = 1'b0;
        check("b_pend_set", b_commit_pending, 1'b1);
        step();
        check("b_pend_clr", b_commit_pending, 1'b0);
        b_enable = 1'b1;
        for (int j = 0; j < 30; j++) begin
            step();
            if (j % 6 == 0) begin
                check("b_code", b_dig_code, 4'h0);
                check("b_ext", b_dig_ext, 1'b1);
                check("b_blank_an", b_an_n, 5'h1F);
            end
            if (j % 6 == 2) begin
                b_an_exp = 5'h1F;
                b_an_exp[j / 6] = 1'b0;
                check("b_on_an", b_an_n, b_an_exp);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/peripheral_scan7seg.md
PERIPHERAL_SCAN7SEG -- requirements
Module: peripheral_scan7seg

Interface
REQ-001 Parameter NDIG, default 4, sets the number of multiplexed 7-segment digits; legal range is 2..8.
REQ-002 Parameter SCAN_DIV, default 50000, sets the number of clk cycles a digit is driven per slot; minimum is 2.
REQ-003 Parameter BLANK_CYC, default 500, sets the number of all-anodes-off clk cycles before each slot; minimum is 1.
REQ-004 Parameter BLINK_FRAMES, default 64, sets the number of full frames per blink phase toggle; minimum is 1.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port enable, input, 1 bit: scanning runs while high.
REQ-008 Port wr_en, input, 1 bit: single-cycle write strobe to the shadow digit registers.
REQ-009 Port wr_addr, input, $clog2(NDIG) bits: index of the shadow digit being written.
REQ-010 Port wr_data, input, 5 bits: bit 4 is the extended-set flag and bits 3:0 are the digit code.
REQ-011 Port commit, input, 1 bit: pulse that requests shadow-to-active copy.
REQ-012 Port blink_mask, input, NDIG bits: a set bit selects that digit to blink.
REQ-013 Port an_n, output, NDIG bits: active-low anode selects.
REQ-014 Port dig_code, output, 4 bits: code for the shared decoder D input.
REQ-015 Port dig_ext, output, 1 bit: value for the shared decoder EXTENDED input.
REQ-016 Port commit_pending, output, 1 bit: high while a commit awaits application.
REQ-017 Port frame_done, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-018 All outputs shall be registered.
REQ-019 The FSM shall have three states, OFF, BLANK and ON, and rst_n low shall force OFF.
REQ-020 In OFF, an_n=all 1s; the digit index resets to 0 and the cycle counter clears.
REQ-021 OFF shall go to BLANK on the first cycle that enable=1.
REQ-022 BLANK shall last exactly BLANK_CYC cycles, with an_n=all 1s and dig_code/dig_ext already driven from the active register at the current index; it then goes to ON.
REQ-023 ON shall last exactly SCAN_DIV cycles, with an_n bit[index]=0 and all other bits 1; it then goes to BLANK with index+1.
REQ-024 On ON exit at index NDIG-1, the index shall wrap to 0 and frame_done shall pulse for that one cycle (the frame boundary).
REQ-025 Each digit period shall be SCAN_DIV+BLANK_CYC cycles, and a frame shall be NDIG times that.
REQ-026 enable=0 in any state shall go to OFF on the next edge, with an_n=all 1s in that same edge and no frame_done.
REQ-027 When wr_en=1 and wr_addr<NDIG, shadow[wr_addr] shall take wr_data on the next edge; a write with wr_addr>=NDIG shall be ignored.
REQ-028 commit=1 shall set commit_pending on the next edge; repeated commits while pending shall have no additional effect.
REQ-029 A pending commit shall copy all shadow registers to active and clear commit_pending at the next frame boundary, or on the next edge if the FSM is in OFF.
REQ-030 A commit asserted in the frame-boundary cycle itself shall apply at the following boundary.
REQ-031 A write in the copy cycle shall land in shadow only, after the copy.
REQ-032 A write and a commit in the same cycle shall both take effect, and the write shall be included in that commit.
REQ-033 The blink phase shall toggle every BLINK_FRAMES frame boundaries and shall clear in OFF.
REQ-034 When phase=1 and blink_mask[index]=1, an_n shall stay all 1s for that ON slot while slot timing is unchanged.
REQ-035 The active and shadow registers shall never be modified by the scan logic.

Reset
REQ-036 While rst_n=0, the FSM shall be in OFF with an_n=all 1s, dig_code=4'b0000, dig_ext=1 (decoder blank code), commit_pending=0, frame_done=0 and blink phase=0.
REQ-037 Reset shall set all shadow and active registers to 5'b10000, so every digit shows blank.
REQ-038 Assertion of rst_n mid-slot shall abort the scan immediately, asynchronously, without a frame_done pulse.
REQ-039 After rst_n deasserts, scanning shall resume only through OFF to BLANK, with index 0.

Verification (NDIG=4, SCAN_DIV=4, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-040 Write 0x01,0x02,0x03,0x04 to addresses 0..3, commit, then enable -> the copy happens in OFF, and the slots show an_n 1110/1101/1011/0111 with dig_code 1..4 and dig_ext 0; each slot has 4 ON cycles and 2 blank cycles, and frame_done fires every 24 cycles.
REQ-041 While scanning, write addr 2=0x0F and commit at mid-frame -> commit_pending stays high until the boundary, and digit 2 shows F from the next frame onward.
REQ-042 Commit in the boundary cycle -> commit_pending stays set for one more full frame, and the copy occurs at the next boundary.
REQ-043 Set blink_mask=4'b0100 -> in frames 3-4, digit 2's slot keeps an_n=1111; frames 1-2 and 5-6 are normal.
REQ-044 Drop enable mid-ON -> an_n=1111 the next cycle; on re-enable, scanning restarts at BLANK, index 0.
REQ-045 Pulse rst_n low mid-slot, then write wr_addr=3'b? out of range (NDIG=4 is 2-bit, so test with NDIG=5, addr 7) -> all outputs are at reset values, and the ignored write changes no digit.
